// File: rtl/cube_sum_acc.sv
// Frame accumulator for the cube engine: captures each done edge once, sums
// N_SAMPLES results with saturation and offers the frame sum on valid/ready.
module cube_sum_acc #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned N_SAMPLES = 4,
    localparam int unsigned CNT_W    = $clog2(N_SAMPLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_done,
    input  logic [DATA_W-1:0] in_result,
    input  logic              frame_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              dropped,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic             done_q;
    logic [ACC_W-1:0] acc;
    logic             frame_ovf;

    logic             cap;
    logic             last;
    logic             slot_free;
    logic [SUM_W-1:0] sum_wide;
    logic             sat;
    logic [ACC_W-1:0] acc_next;

    logic             done_q_d;
    logic [ACC_W-1:0] acc_d;
    logic             frame_ovf_d;
    logic [CNT_W-1:0] sample_cnt_d;
    logic             out_valid_d;
    logic [ACC_W-1:0] out_sum_d;
    logic             out_ovf_d;
    logic             dropped_d;

    // Rising edge of the level-type done; a coincident clear swallows it.
    assign cap       = in_done & ~done_q & ~frame_clear;
    assign last      = (sample_cnt == CNT_W'(N_SAMPLES - 1));
    assign slot_free = ~out_valid | out_ready;

    assign sum_wide  = {1'b0, acc} + SUM_W'(in_result);
    assign sat       = sum_wide[ACC_W];
    assign acc_next  = sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

    always_comb begin
        done_q_d     = in_done;
        acc_d        = acc;
        frame_ovf_d  = frame_ovf;
        sample_cnt_d = sample_cnt;
        out_valid_d  = out_valid & ~out_ready;
        out_sum_d    = out_sum;
        out_ovf_d    = out_ovf;
        dropped_d    = dropped;

        if (frame_clear) begin
            acc_d        = '0;
            frame_ovf_d  = 1'b0;
            sample_cnt_d = '0;
        end else if (cap) begin
            if (last) begin
                acc_d        = '0;
                frame_ovf_d  = 1'b0;
                sample_cnt_d = '0;
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = acc_next;
                    out_ovf_d   = frame_ovf | sat;
                end else begin
                    dropped_d = 1'b1;
                end
            end else begin
                acc_d        = acc_next;
                frame_ovf_d  = frame_ovf | sat;
                sample_cnt_d = sample_cnt + CNT_W'(1);
            end
        end
    end

    // done_q resets high so a level already present at reset release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q     <= 1'b1;
            acc        <= '0;
            frame_ovf  <= 1'b0;
            sample_cnt <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_ovf    <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            done_q     <= done_q_d;
            acc        <= acc_d;
            frame_ovf  <= frame_ovf_d;
            sample_cnt <= sample_cnt_d;
            out_valid  <= out_valid_d;
            out_sum    <= out_sum_d;
            out_ovf    <= out_ovf_d;
            dropped    <= dropped_d;
        end
    end

endmodule
